caliptra_fpga_sync_axil_initiator: RTL and testbench



---
 rtl/caliptra_fpga_sync_axil_initiator_if.sv | 38 +++
 rtl/caliptra_fpga_sync_axil_initiator.sv | 207 ++++++++++++++++++++
 tb/tb_caliptra_fpga_sync_axil_initiator.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/caliptra_fpga_sync_axil_initiator_if.sv
// AXI4-Lite bus (32-bit address, 64-bit data) between the sync initiator and its slave.
interface caliptra_fpga_sync_axil_initiator_if;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awready;
    logic        wvalid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arready;
    logic        rvalid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );
endinterface

// File: rtl/caliptra_fpga_sync_axil_initiator.sv
// Turns a command/response stream into single AXI4-Lite transactions, one outstanding,
// reporting the response code and a saturating issue-to-response latency.
module caliptra_fpga_sync_axil_initiator #(
    parameter logic [2:0]  PROT  = 3'b000,
    parameter int unsigned LAT_W = 16
) (
    input  logic                 aclk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_addr,
    input  logic [63:0]          cmd_wdata,
    input  logic [7:0]           cmd_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_write,
    output logic [63:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic [LAT_W-1:0]     rsp_latency,
    caliptra_fpga_sync_axil_initiator_if.master axi
);

    typedef enum logic [2:0] {
        StIdle, StWrIssue, StWrResp, StRdIssue, StRdData, StRsp
    } state_e;

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0]       addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic [2:0]        prot_q, prot_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [63:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        prot_d      = prot_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        lat_d       = lat_q;

        // Latency counts every bus-wait cycle, handshake cycle included, and saturates.
        if ((state_q == StWrIssue || state_q == StWrResp ||
             state_q == StRdIssue || state_q == StRdData) && lat_q != {LAT_W{1'b1}}) begin
            lat_d = lat_q + LAT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    prot_d      = PROT;
                    lat_d       = '0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    rsp_write_d = cmd_write;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = 2'b00;
                    if (cmd_addr[2:0] != 3'b000) begin
                        rsp_resp_d  = 2'b10;
                        rsp_valid_d = 1'b1;
                        state_d     = StRsp;
                    end else if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrIssue;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRdIssue;
                    end
                end
            end
            StWrIssue: begin
                if (awvalid_q && axi.awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && axi.wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Move on only from the registered done flags; early bvalid is ignored here.
                if (aw_done_q && w_done_q) begin
                    bready_d = 1'b1;
                    state_d  = StWrResp;
                end
            end
            StWrResp: begin
                if (axi.bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = axi.bresp;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRdIssue: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                if (axi.rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = axi.rdata;
                    rsp_resp_d  = axi.rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            prot_q      <= prot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            lat_q       <= lat_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_latency = lat_q;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = prot_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = prot_q;
    assign axi.rready  = rready_q;

endmodule

// File: tb/tb_caliptra_fpga_sync_axil_initiator.sv
// Directed bench for the AXI4-Lite sync initiator: vector table plus reset/saturation sequences.
module tb_caliptra_fpga_sync_axil_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rst4 = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic [7:0]  cmd_wstrb = '0;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [63:0] rdata = '0;

    logic        cmd_ready, rsp_valid, rsp_write, cmd_ready4, rsp_valid4, rsp_write4;
    logic [63:0] rsp_rdata, rsp_rdata4;
    logic [1:0]  rsp_resp, rsp_resp4;
    logic [15:0] rsp_latency;
    logic [3:0]  rsp_latency4;

    caliptra_fpga_sync_axil_initiator_if axi ();
    caliptra_fpga_sync_axil_initiator_if axi4 ();

    assign axi.awready = awready;  assign axi4.awready = awready;
    assign axi.wready  = wready;   assign axi4.wready  = wready;
    assign axi.bvalid  = bvalid;   assign axi4.bvalid  = bvalid;
    assign axi.bresp   = bresp;    assign axi4.bresp   = bresp;
    assign axi.arready = arready;  assign axi4.arready = arready;
    assign axi.rvalid  = rvalid;   assign axi4.rvalid  = rvalid;
    assign axi.rdata   = rdata;    assign axi4.rdata   = rdata;
    assign axi.rresp   = rresp;    assign axi4.rresp   = rresp;

    caliptra_fpga_sync_axil_initiator #(.PROT(3'b000), .LAT_W(16)) dut (
        .aclk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_latency(rsp_latency), .axi(axi)
    );

    caliptra_fpga_sync_axil_initiator #(.PROT(3'b000), .LAT_W(4)) dut4 (
        .aclk(clk), .rst(rst4), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write4), .rsp_rdata(rsp_rdata4), .rsp_resp(rsp_resp4),
        .rsp_latency(rsp_latency4), .axi(axi4)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // *_at: first cycle after acceptance (1-based) at which the slave raises ready/valid; 0 = never.
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          aw_at, w_at, b_at, ar_at, r_at;
        logic [1:0]  bresp, rresp;
        logic [63:0] rdata;
        int          hold;
        int          exp_cyc;
        logic [1:0]  exp_resp;
        logic [63:0] exp_rdata;
        int          exp_lat, exp_awv, exp_wv, exp_arv;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int idx, input vec_t v);
        int c, awv, wv, arv, naw, nw, nar, nb, nr;
        logic seen, b_done, r_done, bus_err, busy_err, hold_err, aligned;
        logic [63:0] s_rdata;
        logic [15:0] s_lat;
        logic [1:0]  s_resp;
        logic        s_write;
        string       p;
        p = $sformatf("v%0d_", idx);
        aligned = (v.addr[2:0] == 3'b000);
        {awv, wv, arv, naw, nw, nar, nb, nr} = '0;
        {seen, b_done, r_done, bus_err, busy_err, hold_err} = '0;
        chk({p, "cmd_ready_idle"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        bresp = v.bresp; rresp = v.rresp; rdata = v.rdata;
        tick();
        cmd_valid = 1'b0;
        c = 1;
        while (c <= 100 && !seen) begin
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                awready = (v.aw_at != 0) && (c >= v.aw_at);
                wready  = (v.w_at != 0) && (c >= v.w_at);
                arready = (v.ar_at != 0) && (c >= v.ar_at);
                bvalid  = (v.b_at != 0) && (c >= v.b_at) && !b_done;
                rvalid  = (v.r_at != 0) && (c >= v.r_at) && !r_done;
                if (cmd_ready) busy_err = 1'b1;
                if (axi.awvalid) begin
                    awv++;
                    if (awready) naw++;
                    if (axi.awaddr != v.addr || axi.awprot != 3'b000) bus_err = 1'b1;
                end
                if (axi.wvalid) begin
                    wv++;
                    if (wready) nw++;
                    if (axi.wdata != v.wdata || axi.wstrb != v.wstrb) bus_err = 1'b1;
                end
                if (axi.arvalid) begin
                    arv++;
                    if (arready) nar++;
                    if (axi.araddr != v.addr || axi.arprot != 3'b000) bus_err = 1'b1;
                end
                if (bvalid && axi.bready) begin nb++; b_done = 1'b1; end
                if (rvalid && axi.rready) begin nr++; r_done = 1'b1; end
                tick();
                c++;
            end
        end
        {awready, wready, arready, bvalid, rvalid} = '0;
        chk({p, "rsp_seen"}, seen, 1);
        chk({p, "rsp_cycle"}, c, v.exp_cyc);
        chk({p, "rsp_write"}, rsp_write, v.wr);
        chk({p, "rsp_resp"}, rsp_resp, v.exp_resp);
        chk({p, "rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({p, "rsp_latency"}, rsp_latency, v.exp_lat);
        chk({p, "aw_beats"}, naw, (v.wr && aligned) ? 1 : 0);
        chk({p, "w_beats"}, nw, (v.wr && aligned) ? 1 : 0);
        chk({p, "ar_beats"}, nar, (!v.wr && aligned) ? 1 : 0);
        chk({p, "b_beats"}, nb, (v.wr && aligned) ? 1 : 0);
        chk({p, "r_beats"}, nr, (!v.wr && aligned) ? 1 : 0);
        chk({p, "awvalid_cycles"}, awv, v.exp_awv);
        chk({p, "wvalid_cycles"}, wv, v.exp_wv);
        chk({p, "arvalid_cycles"}, arv, v.exp_arv);
        chk({p, "bus_fields"}, bus_err, 0);
        chk({p, "cmd_ready_busy"}, busy_err, 0);
        s_write = rsp_write; s_rdata = rsp_rdata; s_resp = rsp_resp; s_lat = rsp_latency;
        for (int h = 0; h < v.hold; h++) begin
            tick();
            if (!rsp_valid || rsp_write != s_write || rsp_rdata != s_rdata ||
                rsp_resp != s_resp || rsp_latency != s_lat || cmd_ready) hold_err = 1'b1;
        end
        if (cmd_ready) hold_err = 1'b1;
        chk({p, "rsp_hold_stable"}, hold_err, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({p, "cmd_ready_after"}, cmd_ready, 1);
        chk({p, "rsp_valid_after"}, rsp_valid, 0);
    endtask

    initial begin
        int   c;
        logic seen, r_done, flag;

        vecs[0] = '{1'b1, 32'h0, 64'h0000_0001_0000_0010, 8'hFF, 1, 1, 1, 0, 0, 2'b00, 2'b00,
                    64'h0, 0, 4, 2'b00, 64'h0, 3, 1, 1, 0};
        vecs[1] = '{1'b0, 32'h8, 64'h0, 8'h00, 0, 0, 0, 3, 7, 2'b00, 2'b00,
                    64'h1234_5678_9ABC_DEF0, 2, 8, 2'b00, 64'h1234_5678_9ABC_DEF0, 7, 0, 0, 3};
        vecs[2] = '{1'b1, 32'h20, 64'hA5A5_0000_FFFF_1234, 8'h3C, 5, 1, 5, 0, 0, 2'b11, 2'b00,
                    64'h0, 0, 8, 2'b11, 64'h0, 7, 5, 1, 0};
        vecs[3] = '{1'b0, 32'h4, 64'h0, 8'h00, 1, 1, 1, 1, 1, 2'b00, 2'b00,
                    64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 2'b10, 64'h0, 0, 0, 0, 0};
        vecs[4] = '{1'b0, 32'h18, 64'h0, 8'h00, 0, 0, 0, 1, 2, 2'b00, 2'b10,
                    64'hDEAD_BEEF_0000_0001, 10, 3, 2'b10, 64'hDEAD_BEEF_0000_0001, 2, 0, 0, 1};
        vecs[5] = '{1'b1, 32'h10, 64'h0123_4567_89AB_CDEF, 8'h0F, 2, 2, 1, 0, 0, 2'b00, 2'b00,
                    64'h0, 0, 5, 2'b00, 64'h0, 4, 2, 2, 0};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_ctrl", {rsp_valid, rsp_write, rsp_resp}, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_latency", rsp_latency, 0);
        chk("rst_axi_ctrl", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
        chk("rst_axi_addr", {axi.awaddr, axi.araddr}, 0);
        chk("rst_axi_data", axi.wdata | {axi.wstrb, axi.awprot, axi.arprot}, 0);

        // Vectors run back to back: each command is presented the cycle cmd_ready returns.
        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // 4-bit latency counter saturates at 15 with a 22-cycle read.
        rst = 1'b1; rst4 = 1'b0;
        tick();
        chk("sat_cmd_ready", cmd_ready4, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
        rdata = 64'h0000_0000_CAFE_F00D; rresp = 2'b00; arready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        c = 1; seen = 1'b0; r_done = 1'b0;
        while (c <= 60 && !seen) begin
            if (rsp_valid4) begin
                seen = 1'b1;
            end else begin
                rvalid = (c >= 22) && !r_done;
                if (rvalid && axi4.rready) r_done = 1'b1;
                tick();
                c++;
            end
        end
        rvalid = 1'b0; arready = 1'b0;
        chk("sat_rsp_seen", seen, 1);
        chk("sat_rsp_cycle", c, 23);
        chk("sat_latency", rsp_latency4, 15);
        chk("sat_rdata", rsp_rdata4, 64'h0000_0000_CAFE_F00D);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        rst4 = 1'b1;

        // Reset while waiting for read data abandons the transaction.
        rst = 1'b0;
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h28; arready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_rready_before", axi.rready, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rready_after", axi.rready, 0);
        chk("mid_cmd_ready_after", cmd_ready, 1);
        chk("mid_rsp_valid_after", rsp_valid, 0);
        chk("mid_arvalid_after", axi.arvalid, 0);
        rvalid = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            tick();
            if (rsp_valid || !cmd_ready || axi.rready) flag = 1'b1;
        end
        rvalid = 1'b0; arready = 1'b0;
        chk("mid_idle_ignores_rvalid", flag, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
